// File: rtl/uart_rx_controller.sv
// uart_rx_controller: sequences one UartRx instance. It captures each received
// byte into a small FIFO, then releases UartRx with a one-cycle clear pulse,
// and hands bytes downstream over valid/ready. Configuration writes are held
// pending until the handoff FSM is idle, so UartRx is never reconfigured mid-byte.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for rx_ready_i; applies pending config when no byte waits
// S_PUSH  | writes the latched byte into the FIFO, or drops it if full
// S_CLEAR | rx_clear_ready_o high for exactly this cycle
// S_WAIT  | holds until rx_ready_i falls, so one byte is never captured twice

module uart_rx_controller #(
    parameter int unsigned FIFO_DEPTH          = 4,
    parameter logic [15:0] DEFAULT_DIVIDER     = 16'd2,
    parameter logic        DEFAULT_PARITY_BIT  = 1'b0,
    parameter logic        DEFAULT_PARITY_EVEN = 1'b0,
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             rx_ready_i,
    input  logic [7:0]       rx_data_i,
    output logic             rx_clear_ready_o,
    output logic [15:0]      rx_clock_divider_o,
    output logic             rx_parity_bit_o,
    output logic             rx_parity_even_o,
    input  logic             cfg_write_i,
    input  logic [15:0]      cfg_divider_i,
    input  logic             cfg_parity_bit_i,
    input  logic             cfg_parity_even_i,
    output logic             cfg_busy_o,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overrun_o,
    input  logic             overrun_clear_i,
    output logic [CNT_W-1:0] count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUSH,
        S_CLEAR,
        S_WAIT
    } state_t;

    state_t           r_state;
    logic [7:0]       r_rx_byte;
    logic             r_clear_ready;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overrun;

    logic [15:0]      r_pend_divider;
    logic             r_pend_parity_bit;
    logic             r_pend_parity_even;
    logic             r_cfg_busy;
    logic [15:0]      r_divider;
    logic             r_parity_bit;
    logic             r_parity_even;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_apply;

    // A full FIFO still has room for the new byte when the consumer pops on the same edge.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop   = !w_empty && ready_i;
    assign w_push  = (r_state == S_PUSH) && (!w_full || w_pop);
    assign w_drop  = (r_state == S_PUSH) && w_full && !w_pop;
    assign w_apply = (r_state == S_IDLE) && !rx_ready_i && r_cfg_busy;

    // Handoff sequencer: capture byte, push, pulse clear, wait for UartRx to drop ready.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= S_IDLE;
            r_rx_byte     <= 8'h00;
            r_clear_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rx_ready_i) begin
                        r_rx_byte <= rx_data_i;
                        r_state   <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    r_clear_ready <= 1'b1;
                    r_state       <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_clear_ready <= 1'b0;
                    r_state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (!rx_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_clear_ready <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because data_o is masked when empty.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_rx_byte;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overrun; a drop on the same edge as a clear request keeps the flag set.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clear_i) begin
            r_overrun <= 1'b0;
        end
    end

    // Pending config: the latest write wins; it is applied only while idle with no byte waiting.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_pend_divider     <= DEFAULT_DIVIDER;
            r_pend_parity_bit  <= DEFAULT_PARITY_BIT;
            r_pend_parity_even <= DEFAULT_PARITY_EVEN;
            r_cfg_busy         <= 1'b0;
            r_divider          <= DEFAULT_DIVIDER;
            r_parity_bit       <= DEFAULT_PARITY_BIT;
            r_parity_even      <= DEFAULT_PARITY_EVEN;
        end else begin
            if (w_apply) begin
                r_divider     <= r_pend_divider;
                r_parity_bit  <= r_pend_parity_bit;
                r_parity_even <= r_pend_parity_even;
                r_cfg_busy    <= 1'b0;
            end
            // A write on the apply edge becomes the next pending value, so busy stays set.
            if (cfg_write_i) begin
                r_pend_divider     <= cfg_divider_i;
                r_pend_parity_bit  <= cfg_parity_bit_i;
                r_pend_parity_even <= cfg_parity_even_i;
                r_cfg_busy         <= 1'b1;
            end
        end
    end

    assign rx_clear_ready_o   = r_clear_ready;
    assign rx_clock_divider_o = r_divider;
    assign rx_parity_bit_o    = r_parity_bit;
    assign rx_parity_even_o   = r_parity_even;
    assign cfg_busy_o         = r_cfg_busy;
    assign data_o             = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign valid_o            = !w_empty;
    assign overrun_o          = r_overrun;
    assign count_o            = r_count;

endmodule
